plasma_mem_arbiter: RTL and testbench

- Two-requester arbiter sharing the Plasma external memory port (address / byte_we / data_write / data_read / mem_pause_in) between the CPU memory master and a DMA master (Ethernet or bulk-copy engine).
- Serialises whole transactions: one outstanding access at a time, registered bus outputs.
- Arbitration is round-robin, or CPU-priority with a DMA starvation guard.
- Sits between the CPU/DMA masters and the off-chip memory interface used in the plasma_modelsim platform.

---
 rtl/plasma_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_plasma_mem_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/plasma_mem_arbiter.sv
// Two-master arbiter for the Plasma external memory port: serialises CPU and DMA
// accesses one at a time, round-robin or CPU-priority with a DMA starvation guard.
module plasma_mem_arbiter #(
  parameter int CPU_PRIORITY = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [29:0] cpu_address,
  input  logic [3:0]  cpu_byte_we,
  input  logic [31:0] cpu_data_write,
  output logic [31:0] cpu_data_read,
  output logic        cpu_ack,
  input  logic        dma_req,
  input  logic [29:0] dma_address,
  input  logic [3:0]  dma_byte_we,
  input  logic [31:0] dma_data_write,
  output logic [31:0] dma_data_read,
  output logic        dma_ack,
  output logic [29:0] address,
  output logic [3:0]  byte_we,
  output logic [31:0] data_write,
  input  logic [31:0] data_read,
  input  logic        mem_pause_in,
  output logic        busy
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic        grant_q, grant_d;            // 1 = DMA owns the current access
  logic        last_grant_q, last_grant_d;  // 1 = DMA completed last
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic [29:0] address_q, address_d;
  logic [3:0]  byte_we_q, byte_we_d;
  logic [31:0] data_write_q, data_write_d;
  logic [31:0] cpu_data_read_q, cpu_data_read_d;
  logic [31:0] dma_data_read_q, dma_data_read_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        dma_ack_q, dma_ack_d;
  logic        busy_q, busy_d;
  logic        pick_dma;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      grant_q         <= 1'b0;
      last_grant_q    <= 1'b1;
      starve_cnt_q    <= 4'd0;
      address_q       <= 30'd0;
      byte_we_q       <= 4'd0;
      data_write_q    <= 32'd0;
      cpu_data_read_q <= 32'd0;
      dma_data_read_q <= 32'd0;
      cpu_ack_q       <= 1'b0;
      dma_ack_q       <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      last_grant_q    <= last_grant_d;
      starve_cnt_q    <= starve_cnt_d;
      address_q       <= address_d;
      byte_we_q       <= byte_we_d;
      data_write_q    <= data_write_d;
      cpu_data_read_q <= cpu_data_read_d;
      dma_data_read_q <= dma_data_read_d;
      cpu_ack_q       <= cpu_ack_d;
      dma_ack_q       <= dma_ack_d;
      busy_q          <= busy_d;
    end
  end

  // Tie-break: priority mode yields to DMA only once the guard has saturated.
  always_comb begin
    pick_dma = dma_req;
    if (cpu_req && dma_req) begin
      if (CPU_PRIORITY != 0) pick_dma = (starve_cnt_q == LIMIT);
      else                   pick_dma = ~last_grant_q;
    end
  end

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    last_grant_d    = last_grant_q;
    starve_cnt_d    = starve_cnt_q;
    address_d       = address_q;
    byte_we_d       = byte_we_q;
    data_write_d    = data_write_q;
    cpu_data_read_d = cpu_data_read_q;
    dma_data_read_d = dma_data_read_q;
    cpu_ack_d       = 1'b0;
    dma_ack_d       = 1'b0;
    busy_d          = busy_q;
    case (state_q)
      IDLE: begin
        if (cpu_req || dma_req) begin
          grant_d      = pick_dma;
          address_d    = pick_dma ? dma_address    : cpu_address;
          byte_we_d    = pick_dma ? dma_byte_we    : cpu_byte_we;
          data_write_d = pick_dma ? dma_data_write : cpu_data_write;
          busy_d       = 1'b1;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        if (!mem_pause_in) begin
          if (grant_q) begin
            dma_data_read_d = data_read;
            dma_ack_d       = 1'b1;
            starve_cnt_d    = 4'd0;
          end else begin
            cpu_data_read_d = data_read;
            cpu_ack_d       = 1'b1;
            // Count CPU wins that happened while DMA was waiting.
            if (!dma_req)                   starve_cnt_d = 4'd0;
            else if (starve_cnt_q != LIMIT) starve_cnt_d = starve_cnt_q + 4'd1;
          end
          last_grant_d = grant_q;
          byte_we_d    = 4'd0;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cpu_data_read = cpu_data_read_q;
  assign dma_data_read = dma_data_read_q;
  assign cpu_ack       = cpu_ack_q;
  assign dma_ack       = dma_ack_q;
  assign address       = address_q;
  assign byte_we       = byte_we_q;
  assign data_write    = data_write_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_plasma_mem_arbiter.sv
// Scoreboard bench for plasma_mem_arbiter: a round-robin and a CPU-priority
// instance share the stimulus; acks are matched against queued expectations.
module tb_plasma_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, dma_req, mem_pause_in;
  logic [29:0] cpu_address, dma_address;
  logic [3:0]  cpu_byte_we, dma_byte_we;
  logic [31:0] cpu_data_write, dma_data_write, data_read;
  logic        sel_prio;

  logic [31:0] r_cpu_dr, r_dma_dr, r_dw, p_cpu_dr, p_dma_dr, p_dw;
  logic        r_cpu_ack, r_dma_ack, r_busy, p_cpu_ack, p_dma_ack, p_busy;
  logic [29:0] r_addr, p_addr;
  logic [3:0]  r_we, p_we;

  typedef struct {
    logic        is_dma;
    logic [31:0] data;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;
  int   cyc, total;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [29:0] a);
    if (a == 30'h100) return 32'hDEADBEEF;
    return {a, 2'b01} ^ 32'h5A5A_0000;
  endfunction

  plasma_mem_arbiter #(.CPU_PRIORITY(0), .STARVE_LIMIT(4)) u_rr (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_address(cpu_address), .cpu_byte_we(cpu_byte_we),
    .cpu_data_write(cpu_data_write), .cpu_data_read(r_cpu_dr), .cpu_ack(r_cpu_ack),
    .dma_req(dma_req), .dma_address(dma_address), .dma_byte_we(dma_byte_we),
    .dma_data_write(dma_data_write), .dma_data_read(r_dma_dr), .dma_ack(r_dma_ack),
    .address(r_addr), .byte_we(r_we), .data_write(r_dw), .data_read(data_read),
    .mem_pause_in(mem_pause_in), .busy(r_busy)
  );

  plasma_mem_arbiter #(.CPU_PRIORITY(1), .STARVE_LIMIT(4)) u_prio (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_address(cpu_address), .cpu_byte_we(cpu_byte_we),
    .cpu_data_write(cpu_data_write), .cpu_data_read(p_cpu_dr), .cpu_ack(p_cpu_ack),
    .dma_req(dma_req), .dma_address(dma_address), .dma_byte_we(dma_byte_we),
    .dma_data_write(dma_data_write), .dma_data_read(p_dma_dr), .dma_ack(p_dma_ack),
    .address(p_addr), .byte_we(p_we), .data_write(p_dw), .data_read(data_read),
    .mem_pause_in(mem_pause_in), .busy(p_busy)
  );

  wire        ack_c = sel_prio ? p_cpu_ack : r_cpu_ack;
  wire        ack_d = sel_prio ? p_dma_ack : r_dma_ack;
  wire [31:0] dr_c  = sel_prio ? p_cpu_dr  : r_cpu_dr;
  wire [31:0] dr_d  = sel_prio ? p_dma_dr  : r_dma_dr;
  wire        bsy   = sel_prio ? p_busy    : r_busy;

  assign data_read = mem_fn(sel_prio ? p_addr : r_addr);

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input logic is_dma, input logic [29:0] a);
    exp_t x;
    x.is_dma = is_dma;
    x.data   = mem_fn(a);
    sbq.push_back(x);
  endtask

  // Returns at #1 after the edge that produced the next ack of the selected instance.
  task automatic wait_ack(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(ack_c || ack_d) && n < 50);
    if (!(ack_c || ack_d)) check_val("ack_timeout", 32'(n), 32'd0);
  endtask

  always @(negedge clk) begin
    if (bsy) busy_cnt++;
    if (ack_c && ack_d) check_val("ack_overlap", {31'd0, ack_d}, 32'd0);
    else if (ack_c || ack_d) begin
      if (sbq.size() == 0) check_val("unexpected_ack", 32'(sbq.size()), 32'd1);
      else begin
        e = sbq.pop_front();
        check_val("grant_dma", {31'd0, ack_d}, {31'd0, e.is_dma});
        check_val("rdata", ack_d ? dr_d : dr_c, e.data);
      end
    end
  end

  initial begin
    reset = 1'b1; sel_prio = 1'b0;
    cpu_req = 0; dma_req = 0; mem_pause_in = 0;
    cpu_address = '0; dma_address = '0; cpu_byte_we = '0; dma_byte_we = '0;
    cpu_data_write = '0; dma_data_write = '0;
    repeat (2) @(posedge clk); #1;
    check_val("rst_addr", {2'b0, r_addr}, 32'd0);
    check_val("rst_busy", {31'd0, r_busy}, 32'd0);
    check_val("rst_acks", {30'd0, r_cpu_ack, r_dma_ack}, 32'd0);
    reset = 1'b0;

    // Single CPU read
    @(posedge clk); #1;
    cpu_req = 1; cpu_address = 30'h100; cpu_byte_we = 4'd0;
    push(1'b0, 30'h100);
    @(posedge clk); #1;
    check_val("t1_addr", {2'b0, r_addr}, 32'h100);
    check_val("t1_we", {28'd0, r_we}, 32'd0);
    check_val("t1_busy", {31'd0, r_busy}, 32'd1);
    @(posedge clk); #1;
    check_val("t1_ack", {31'd0, r_cpu_ack}, 32'd1);
    check_val("t1_data", r_cpu_dr, 32'hDEADBEEF);
    cpu_req = 0;
    @(posedge clk); #1;
    check_val("t1_idle_busy", {31'd0, r_busy}, 32'd0);

    // DMA write with three stall cycles
    dma_req = 1; dma_address = 30'h2A5; dma_byte_we = 4'b0011;
    dma_data_write = 32'h12345678; mem_pause_in = 1;
    push(1'b1, 30'h2A5);
    busy_cnt = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      check_val("t2_addr", {2'b0, r_addr}, 32'h2A5);
      check_val("t2_we", {28'd0, r_we}, 32'd3);
      check_val("t2_dw", r_dw, 32'h12345678);
      @(posedge clk); #1;
    end
    check_val("t2_no_early_ack", {31'd0, r_dma_ack}, 32'd0);
    mem_pause_in = 0;
    @(posedge clk); #1;
    check_val("t2_ack", {31'd0, r_dma_ack}, 32'd1);
    check_val("t2_we_clr", {28'd0, r_we}, 32'd0);
    check_val("t2_addr_hold", {2'b0, r_addr}, 32'h2A5);
    dma_req = 0; dma_byte_we = 0;
    @(posedge clk); #1;
    check_val("t2_busy_cycles", 32'(busy_cnt), 32'd4);

    // Round-robin with both masters continuously requesting
    cpu_address = 30'h011; dma_address = 30'h322;
    for (int i = 0; i < 3; i++) begin push(1'b0, 30'h011); push(1'b1, 30'h322); end
    cpu_req = 1; dma_req = 1; total = 0;
    for (int i = 0; i < 6; i++) begin wait_ack(cyc); total += cyc; end
    cpu_req = 0; dma_req = 0;
    check_val("t3_cycles", 32'(total), 32'd12);

    // CPU request held through its ack; DMA raised mid-access wins next
    @(posedge clk); #1;
    cpu_req = 1; cpu_address = 30'h044; dma_address = 30'h055;
    push(1'b0, 30'h044); push(1'b1, 30'h055); push(1'b0, 30'h044);
    @(posedge clk); #1;
    dma_req = 1;
    wait_ack(cyc);
    wait_ack(cyc);
    dma_req = 0;
    wait_ack(cyc);
    cpu_req = 0;
    @(posedge clk); #1;

    // Reset mid-access while stalled
    cpu_req = 1; cpu_address = 30'h066; mem_pause_in = 1;
    @(posedge clk); #1;
    check_val("t5_busy_pre", {31'd0, r_busy}, 32'd1);
    @(posedge clk); #2;
    reset = 1; dma_req = 1; dma_address = 30'h077;
    #1;
    check_val("t5_addr", {2'b0, r_addr}, 32'd0);
    check_val("t5_bus", {r_we, r_busy, r_cpu_ack, r_dma_ack}, 32'd0);
    check_val("t5_dw", r_dw, 32'd0);
    check_val("t5_dr", r_cpu_dr | r_dma_dr, 32'd0);
    @(posedge clk); #1;
    reset = 0; mem_pause_in = 0;
    push(1'b0, 30'h066);
    wait_ack(cyc);
    cpu_req = 0; dma_req = 0;
    check_val("t5_lat", 32'(cyc), 32'd2);

    // CPU priority with starvation guard
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0; sel_prio = 1;
    cpu_address = 30'h0AA; dma_address = 30'h0BB;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) push(1'b0, 30'h0AA);
      push(1'b1, 30'h0BB);
    end
    cpu_req = 1; dma_req = 1;
    for (int i = 0; i < 10; i++) wait_ack(cyc);
    cpu_req = 0; dma_req = 0;
    repeat (3) @(posedge clk); #1;

    check_val("sb_drain", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
